// File: rtl/uart_rx.sv
// UART receive deserializer: start/data/parity/stop framing recovered from an
// oversampled serial line with 3-sample majority voting per bit.
module uart_rx #(
    parameter int DATA_WD = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic [5:0]         PRESCALE,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    output logic [DATA_WD-1:0] P_DATA,
    output logic               DATA_VALID,
    output logic               PAR_ERR,
    output logic               STP_ERR
);

    localparam int BW = (DATA_WD > 1) ? $clog2(DATA_WD) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t             r_state;
    logic [5:0]         r_edge_cnt;
    logic [BW-1:0]      r_bit_cnt;
    logic [DATA_WD-1:0] r_shift;
    logic [5:0]         r_prescale;
    logic               r_par_en;
    logic               r_par_typ;
    logic               r_par_mis;
    logic               r_s0;
    logic               r_s1;
    logic               r_s2;
    logic [DATA_WD-1:0] r_p_data;
    logic               r_data_valid;
    logic               r_par_err;
    logic               r_stp_err;

    logic [5:0] w_half;
    logic       w_last;
    logic       w_chk;
    logic       w_vote;
    logic       w_par_exp;
    logic       w_stop_bad;
    logic       w_par_bad;

    // Timing is always taken from the latched prescale, never the live input.
    assign w_half     = r_prescale >> 1;
    assign w_last     = (r_edge_cnt == r_prescale - 6'd1);
    assign w_chk      = (r_edge_cnt == w_half + 6'd2);
    assign w_vote     = (r_s0 & r_s1) | (r_s0 & r_s2) | (r_s1 & r_s2);
    assign w_par_exp  = (^r_shift) ^ r_par_typ;
    assign w_stop_bad = ~w_vote;
    assign w_par_bad  = r_par_en & r_par_mis;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state      <= S_IDLE;
            r_edge_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_prescale   <= 6'd16;
            r_par_en     <= 1'b0;
            r_par_typ    <= 1'b0;
            r_par_mis    <= 1'b0;
            r_s0         <= 1'b1;
            r_s1         <= 1'b1;
            r_s2         <= 1'b1;
            r_p_data     <= '0;
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;

            if (r_state != S_IDLE) begin
                if (r_edge_cnt == w_half - 6'd1) r_s0 <= RX_IN;
                if (r_edge_cnt == w_half)        r_s1 <= RX_IN;
                if (r_edge_cnt == w_half + 6'd1) r_s2 <= RX_IN;
                r_edge_cnt <= w_last ? '0 : r_edge_cnt + 6'd1;
            end

            case (r_state)
                S_IDLE: begin
                    r_edge_cnt <= '0;
                    if (!RX_IN) begin
                        r_state    <= S_START;
                        r_edge_cnt <= 6'd1;
                        r_bit_cnt  <= '0;
                        r_par_mis  <= 1'b0;
                        r_prescale <= PRESCALE;
                        r_par_en   <= PAR_EN;
                        r_par_typ  <= PAR_TYP;
                    end
                end

                S_START: begin
                    if (w_chk && w_vote) begin
                        r_state    <= S_IDLE;
                        r_edge_cnt <= '0;
                    end else if (w_last) begin
                        r_state   <= S_DATA;
                        r_bit_cnt <= '0;
                    end
                end

                S_DATA: begin
                    if (w_last) begin
                        r_shift   <= {w_vote, r_shift[DATA_WD-1:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == BW'(DATA_WD - 1))
                            r_state <= r_par_en ? S_PARITY : S_STOP;
                    end
                end

                S_PARITY: begin
                    if (w_last) begin
                        r_par_mis <= (w_par_exp != w_vote);
                        r_state   <= S_STOP;
                    end
                end

                S_STOP: begin
                    if (w_last) begin
                        r_stp_err <= w_stop_bad;
                        r_par_err <= w_par_bad;
                        if (!w_stop_bad && !w_par_bad) begin
                            r_data_valid <= 1'b1;
                            r_p_data     <= r_shift;
                        end
                        // A low line on the closing edge is the next start bit's edge 0.
                        if (!RX_IN) begin
                            r_state    <= S_START;
                            r_edge_cnt <= 6'd1;
                            r_bit_cnt  <= '0;
                            r_par_mis  <= 1'b0;
                            r_prescale <= PRESCALE;
                            r_par_en   <= PAR_EN;
                            r_par_typ  <= PAR_TYP;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_edge_cnt <= '0;
                end
            endcase
        end
    end

    assign P_DATA     = r_p_data;
    assign DATA_VALID = r_data_valid;
    assign PAR_ERR    = r_par_err;
    assign STP_ERR    = r_stp_err;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven bit-by-bit per cycle and the
// strobe edges, counts and data are compared with hand-computed values.
module tb_uart_rx;

    logic       CLK;
    logic       RST;
    logic       RX_IN;
    logic [5:0] PRESCALE;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_ERR;
    logic       STP_ERR;

    int n_chk;
    int n_err;
    int dv_n, pe_n, se_n;
    int dv_at, pe_at, se_at;

    uart_rx #(.DATA_WD(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PRESCALE   (PRESCALE),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_ERR    (PAR_ERR),
        .STP_ERR    (STP_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic clr_strobes();
        dv_n = 0; pe_n = 0; se_n = 0;
        dv_at = -1; pe_at = -1; se_at = -1;
    endtask

    // Wait one rising edge and log any strobe seen after it, tagged with edge index k.
    task automatic tick(input int k);
        @(posedge CLK);
        #1;
        if (DATA_VALID) begin dv_n++; dv_at = k; end
        if (PAR_ERR)    begin pe_n++; pe_at = k; end
        if (STP_ERR)    begin se_n++; se_at = k; end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge CLK);
            RX_IN = 1'b1;
            tick(-1);
        end
    endtask

    // Drive one frame; edge 0 is the first edge with RX_IN low. gl inverts the
    // line on that one edge, abort_at asserts reset on that edge and stops.
    task automatic send_frame(input logic [7:0] d, input int p, input bit pe,
                              input bit ptyp, input bit pbit, input bit stopb,
                              input int gl, input int abort_at);
        int  nb;
        int  b;
        logic v;
        nb = pe ? 11 : 10;
        clr_strobes();
        for (int k = 0; k < nb * p; k++) begin
            @(negedge CLK);
            if (k == 0) begin
                PRESCALE = 6'(p);
                PAR_EN   = pe;
                PAR_TYP  = ptyp;
            end
            if (k == abort_at) begin
                RST = 1'b0;
                return;
            end
            b = k / p;
            if (b == 0)               v = 1'b0;
            else if (b <= 8)          v = d[b-1];
            else if (pe && b == 9)    v = pbit;
            else                      v = stopb;
            if (k == gl) v = ~v;
            RX_IN = v;
            tick(k);
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        clr_strobes();
        RST      = 1'b0;
        RX_IN    = 1'b1;
        PRESCALE = 6'd16;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_pdata", int'(P_DATA), 0);
        chk("rst_dv",    int'(DATA_VALID), 0);
        chk("rst_pe",    int'(PAR_ERR), 0);
        chk("rst_se",    int'(STP_ERR), 0);
        @(negedge CLK);
        RST = 1'b1;
        idle(4);

        // Clean frame, P=16, no parity
        send_frame(8'hA5, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(4);
        chk("clean_dv_n",  dv_n, 1);
        chk("clean_dv_at", dv_at, 159);
        chk("clean_data",  int'(P_DATA), 8'hA5);
        chk("clean_errs",  pe_n + se_n, 0);

        // Reset mid-frame discards partial frame and clears P_DATA
        send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1, 40);
        #1;
        chk("mrst_pdata", int'(P_DATA), 0);
        chk("mrst_strb",  int'(DATA_VALID) + int'(PAR_ERR) + int'(STP_ERR), 0);
        @(negedge CLK);
        RX_IN = 1'b1;
        RST   = 1'b1;
        clr_strobes();
        idle(200);
        chk("mrst_quiet", dv_n + pe_n + se_n, 0);
        send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(4);
        chk("mrst_dv_at", dv_at, 159);
        chk("mrst_data",  int'(P_DATA), 8'h3C);

        // P=8, even parity, 0x0F with parity bit 0
        send_frame(8'h0F, 8, 1'b1, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(4);
        chk("pev_dv_n",  dv_n, 1);
        chk("pev_dv_at", dv_at, 87);
        chk("pev_data",  int'(P_DATA), 8'h0F);
        chk("pev_pe_n",  pe_n, 0);

        // Same frame, parity bit flipped
        send_frame(8'h0F, 8, 1'b1, 1'b0, 1'b1, 1'b1, -1, -1);
        idle(4);
        chk("pbad_pe_n",  pe_n, 1);
        chk("pbad_pe_at", pe_at, 87);
        chk("pbad_dv_n",  dv_n, 0);
        chk("pbad_se_n",  se_n, 0);
        chk("pbad_data",  int'(P_DATA), 8'h0F);

        // Odd parity, 0x01 with parity bit 0
        send_frame(8'h01, 8, 1'b1, 1'b1, 1'b0, 1'b1, -1, -1);
        idle(4);
        chk("podd_dv_n", dv_n, 1);
        chk("podd_data", int'(P_DATA), 8'h01);
        chk("podd_pe_n", pe_n, 0);

        // Stop error, P=32
        send_frame(8'h55, 32, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
        idle(64);
        chk("stp_se_n",  se_n, 1);
        chk("stp_se_at", se_at, 319);
        chk("stp_dv_n",  dv_n, 0);
        chk("stp_pe_n",  pe_n, 0);
        chk("stp_data",  int'(P_DATA), 8'h01);

        // Short 3-cycle low glitch on idle line
        clr_strobes();
        PRESCALE = 6'd16;
        PAR_EN   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            RX_IN = 1'b0;
            tick(k);
        end
        idle(60);
        chk("glitch_strb", dv_n + pe_n + se_n, 0);
        chk("glitch_data", int'(P_DATA), 8'h01);

        // Inverted sample at P/2 of data bit 3 (frame bit 4)
        send_frame(8'hA5, 16, 1'b0, 1'b0, 1'b0, 1'b1, 4 * 16 + 8, -1);
        idle(4);
        chk("vote_dv_n", dv_n, 1);
        chk("vote_data", int'(P_DATA), 8'hA5);

        // Back-to-back frames with no idle gap
        send_frame(8'hC3, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
        chk("b2b1_dv_n",  dv_n, 1);
        chk("b2b1_dv_at", dv_at, 159);
        chk("b2b1_data",  int'(P_DATA), 8'hC3);
        send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(4);
        chk("b2b2_dv_n",  dv_n, 1);
        chk("b2b2_dv_at", dv_at, 159);
        chk("b2b2_data",  int'(P_DATA), 8'h3C);
        chk("b2b2_errs",  pe_n + se_n, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
